// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pooling window buffer and the comparator-tree stage.
// Provides the window element index mapping and the packed window width.
package maxpool_pkg;

  localparam int DEF_STRIDE_SIZE = 32'sd2;
  localparam int DEF_DATA_WIDTH  = 32'sd16;

  // Packed window width used by the comparator tree at default parameters.
  localparam int WIN_W = DEF_STRIDE_SIZE * DEF_STRIDE_SIZE * DEF_DATA_WIDTH;

  // Element index of window row r (top-down), column c (left-right).
  function automatic int win_idx(input int r, input int c, input int s);
    return r * s + c;
  endfunction

  // Packed window width for an arbitrary stride and pixel width.
  function automatic int win_width(input int s, input int dw);
    return s * s * dw;
  endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// One image-row RAM: single write port and one asynchronous read port
// sharing the same column address.
module maxpool_line_buffer
  import maxpool_pkg::*;
#(
  parameter int DEPTH      = 32'sd28,
  parameter int DATA_WIDTH = 32'sd16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Row storage; contents are never cleared because every entry is written before use.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[addr];

endmodule

// File: rtl/maxpool_window_buffer.sv
// Streaming line buffer assembling non-overlapping STRIDE_SIZE x STRIDE_SIZE
// pooling windows from a raster pixel stream.
// Optional macro MAXPOOL_WINDOW_BACKPRESSURE_EN adds out_ready/data_in_ready
// so a finished window can be held until the downstream stage takes it.
module maxpool_window_buffer
  import maxpool_pkg::*;
#(
  parameter int STRIDE_SIZE = 32'sd2,
  parameter int DATA_WIDTH  = 32'sd16,
  parameter int ROW_SIZE    = 32'sd28,
  parameter int COLUMN_SIZE = 32'sd28
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [DATA_WIDTH-1:0]                       data_in,
  input  logic                                        data_in_valid,
`ifdef MAXPOOL_WINDOW_BACKPRESSURE_EN
  input  logic                                        out_ready,
  output logic                                        data_in_ready,
`endif
  output logic [STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                        window_valid,
  output logic                                        window_last
);

  localparam int S  = STRIDE_SIZE;
  localparam int CW = $clog2(ROW_SIZE);
  localparam int RW = $clog2(COLUMN_SIZE);
  localparam int PW = $clog2(STRIDE_SIZE);
  localparam int WW = STRIDE_SIZE * STRIDE_SIZE * DATA_WIDTH;

  localparam logic [CW-1:0] COL_CNT_LAST = CW'(ROW_SIZE - 32'sd1);
  localparam logic [RW-1:0] ROW_CNT_LAST = RW'(COLUMN_SIZE - 32'sd1);
  localparam logic [PW-1:0] PH_LAST      = PW'(STRIDE_SIZE - 32'sd1);

  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  // Position inside the current window, kept separately so no modulo is needed.
  logic [PW-1:0] col_ph_q, col_ph_d;
  logic [PW-1:0] row_ph_q, row_ph_d;

  // Per window row, the last S-1 pixels of that row seen in the current column band.
  logic [DATA_WIDTH-1:0] hist_q [S][S-1];
  logic [DATA_WIDTH-1:0] hist_d [S][S-1];

  logic [WW-1:0] window_out_q, window_out_d;
  logic          window_valid_q, window_valid_d;
  logic          window_last_q, window_last_d;

  logic [DATA_WIDTH-1:0] rd_data_s [S-1];
  logic [DATA_WIDTH-1:0] col_vec_s [S];
  logic [S-2:0]          ram_we_s;
  logic                  accept_s;
  logic                  consume_s;
  logic                  emit_s;
  logic                  last_pix_s;

`ifdef MAXPOOL_WINDOW_BACKPRESSURE_EN
  assign data_in_ready = !window_valid_q || out_ready;
  assign accept_s      = data_in_valid && data_in_ready;
  assign consume_s     = window_valid_q && out_ready;
`else
  assign accept_s      = data_in_valid;
  assign consume_s     = 1'b1;
`endif

  assign emit_s     = accept_s && (col_ph_q == PH_LAST) && (row_ph_q == PH_LAST);
  assign last_pix_s = (col_cnt_q == COL_CNT_LAST) && (row_cnt_q == ROW_CNT_LAST);

  // Rows of the current band rotate through the S-1 RAMs; the last row is never stored.
  for (genvar g = 0; g < S - 1; g++) begin : g_row_ram
    assign ram_we_s[g] = accept_s && (row_ph_q == PW'(g));
    maxpool_line_buffer #(
      .DEPTH      (ROW_SIZE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_row_ram (
      .clock   (clock),
      .wr_en   (ram_we_s[g]),
      .addr    (col_cnt_q),
      .wr_data (data_in),
      .rd_data (rd_data_s[g])
    );
  end

  // Column of the current window: stored rows from the RAMs, bottom row is the live pixel.
  always_comb begin
    for (int k = 0; k < S - 1; k++) begin
      col_vec_s[k] = rd_data_s[k];
    end
    col_vec_s[S-1] = data_in;
  end

  // Raster position and in-window phase counters, advanced only on accepted pixels.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    col_ph_d  = col_ph_q;
    row_ph_d  = row_ph_q;
    if (accept_s) begin
      if (col_cnt_q == COL_CNT_LAST) begin
        col_cnt_d = '0;
        col_ph_d  = '0;
        if (row_cnt_q == ROW_CNT_LAST) begin
          row_cnt_d = '0;
          row_ph_d  = '0;
        end else begin
          row_cnt_d = row_cnt_q + RW'(1);
          row_ph_d  = (row_ph_q == PH_LAST) ? '0 : row_ph_q + PW'(1);
        end
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
        col_ph_d  = (col_ph_q == PH_LAST) ? '0 : col_ph_q + PW'(1);
      end
    end else begin
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
    end
  end

  // Shift each window row's history by one column on every accepted pixel.
  always_comb begin
    hist_d = hist_q;
    if (accept_s) begin
      for (int r = 0; r < S; r++) begin
        for (int k = 0; k < S - 2; k++) begin
          hist_d[r][k] = hist_q[r][k+1];
        end
        hist_d[r][S-2] = col_vec_s[r];
      end
    end else begin
      hist_d = hist_q;
    end
  end

  // Output register: load a completed window, otherwise retire it once consumed.
  always_comb begin
    window_out_d   = window_out_q;
    window_valid_d = window_valid_q;
    window_last_d  = window_last_q;
    if (emit_s) begin
      window_valid_d = 1'b1;
      window_last_d  = last_pix_s;
      for (int r = 0; r < S; r++) begin
        for (int c = 0; c < S - 1; c++) begin
          window_out_d[win_idx(r, c, S)*DATA_WIDTH +: DATA_WIDTH] = hist_q[r][c];
        end
        window_out_d[win_idx(r, S - 1, S)*DATA_WIDTH +: DATA_WIDTH] = col_vec_s[r];
      end
    end else if (consume_s) begin
      window_valid_d = 1'b0;
      window_last_d  = 1'b0;
    end else begin
      window_valid_d = window_valid_q;
      window_last_d  = window_last_q;
    end
  end

  // State registers with synchronous reset; a reset drops any partial frame or pending window.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_cnt_q      <= '0;
      row_cnt_q      <= '0;
      col_ph_q       <= '0;
      row_ph_q       <= '0;
      hist_q         <= '{default: '0};
      window_out_q   <= '0;
      window_valid_q <= 1'b0;
      window_last_q  <= 1'b0;
    end else begin
      col_cnt_q      <= col_cnt_d;
      row_cnt_q      <= row_cnt_d;
      col_ph_q       <= col_ph_d;
      row_ph_q       <= row_ph_d;
      hist_q         <= hist_d;
      window_out_q   <= window_out_d;
      window_valid_q <= window_valid_d;
      window_last_q  <= window_last_d;
    end
  end

  assign window_out   = window_out_q;
  assign window_valid = window_valid_q;
  assign window_last  = window_last_q;

endmodule

// File: tb/tb_maxpool_window_buffer.sv
// Self-checking bench for maxpool_window_buffer. Three instances:
//   A: S=2, 4x4 frame   B: S=2, 28x28 frame   C: S=3, 6x6 frame
// Expected windows come from a frame image held in the bench, indexed by raster position.
module tb_maxpool_window_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [15:0]  din_a, din_b, din_c;
  logic         vld_a, vld_b, vld_c;
  logic [63:0]  win_a, win_b;
  logic [143:0] win_c;
  logic         wv_a, wv_b, wv_c;
  logic         wl_a, wl_b, wl_c;
`ifdef MAXPOOL_WINDOW_BACKPRESSURE_EN
  logic out_rdy_a, rdy_a, rdy_b, rdy_c;
`endif

  maxpool_window_buffer #(.STRIDE_SIZE(2), .DATA_WIDTH(16), .ROW_SIZE(4), .COLUMN_SIZE(4)) dut_a (
    .clock(clk), .reset(reset), .data_in(din_a), .data_in_valid(vld_a),
`ifdef MAXPOOL_WINDOW_BACKPRESSURE_EN
    .out_ready(out_rdy_a), .data_in_ready(rdy_a),
`endif
    .window_out(win_a), .window_valid(wv_a), .window_last(wl_a));

  maxpool_window_buffer #(.STRIDE_SIZE(2), .DATA_WIDTH(16), .ROW_SIZE(28), .COLUMN_SIZE(28)) dut_b (
    .clock(clk), .reset(reset), .data_in(din_b), .data_in_valid(vld_b),
`ifdef MAXPOOL_WINDOW_BACKPRESSURE_EN
    .out_ready(1'b1), .data_in_ready(rdy_b),
`endif
    .window_out(win_b), .window_valid(wv_b), .window_last(wl_b));

  maxpool_window_buffer #(.STRIDE_SIZE(3), .DATA_WIDTH(16), .ROW_SIZE(6), .COLUMN_SIZE(6)) dut_c (
    .clock(clk), .reset(reset), .data_in(din_c), .data_in_valid(vld_c),
`ifdef MAXPOOL_WINDOW_BACKPRESSURE_EN
    .out_ready(1'b1), .data_in_ready(rdy_c),
`endif
    .window_out(win_c), .window_valid(wv_c), .window_last(wl_c));

  int n_assert = 0;
  int n_fail   = 0;

  int S_   [3] = '{2, 2, 3};
  int ROW_ [3] = '{4, 28, 6};
  int COL_ [3] = '{4, 28, 6};
  logic [15:0] img [3][784];
  int pos     [3] = '{0, 0, 0};
  int win_cnt [3] = '{0, 0, 0};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] act_win(input int d);
    case (d)
      0:       return {192'd0, win_a};
      1:       return {192'd0, win_b};
      2:       return {112'd0, win_c};
      default: return 256'd0;
    endcase
  endfunction

  function automatic logic act_v(input int d);
    case (d)
      0:       return wv_a;
      1:       return wv_b;
      2:       return wv_c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic act_l(input int d);
    case (d)
      0:       return wl_a;
      1:       return wl_b;
      2:       return wl_c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_in(input int d, input logic v, input logic [15:0] px);
    case (d)
      0: begin din_a = px; vld_a = v; end
      1: begin din_b = px; vld_b = v; end
      default: begin din_c = px; vld_c = v; end
    endcase
  endtask

  // Reference: window ending at raster (r,c) is the S x S block of the stored image.
  function automatic logic [255:0] model_win(input int d, input int r, input int c);
    logic [255:0] w;
    int s;
    s = S_[d];
    w = 256'd0;
    for (int i = 0; i < s; i++)
      for (int j = 0; j < s; j++)
        w[(i*s+j)*16 +: 16] = img[d][(r-s+1+i)*ROW_[d] + (c-s+1+j)];
    return w;
  endfunction

  // One accepted pixel on instance d, then check the cycle after acceptance.
  task automatic beat(input int d, input logic [15:0] px);
    int r, c;
    logic ev, el;
    r = pos[d] / ROW_[d];
    c = pos[d] % ROW_[d];
    img[d][pos[d]] = px;
    ev = (r % S_[d] == S_[d]-1) && (c % S_[d] == S_[d]-1);
    el = ev && (r == COL_[d]-1) && (c == ROW_[d]-1);
    set_in(d, 1'b1, px);
    @(posedge clk); #1;
    set_in(d, 1'b0, px);
    chk($sformatf("valid d%0d p%0d", d, pos[d]), {255'd0, act_v(d)}, {255'd0, ev});
    chk($sformatf("last d%0d p%0d", d, pos[d]), {255'd0, act_l(d)}, {255'd0, el});
    if (ev) chk($sformatf("win d%0d p%0d", d, pos[d]), act_win(d), model_win(d, r, c));
    if (act_v(d)) win_cnt[d]++;
    pos[d] = (pos[d] + 1) % (ROW_[d] * COL_[d]);
  endtask

  task automatic idle(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk($sformatf("gap valid d%0d", d), {255'd0, act_v(d)}, 256'd0);
    end
  endtask

  task automatic check_reset_state();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst valid d%0d", d), {255'd0, act_v(d)}, 256'd0);
      chk($sformatf("rst last d%0d", d), {255'd0, act_l(d)}, 256'd0);
      chk($sformatf("rst win d%0d", d), act_win(d), 256'd0);
    end
`ifdef MAXPOOL_WINDOW_BACKPRESSURE_EN
    chk("rst ready a", {255'd0, rdy_a}, {255'd0, 1'b1});
`endif
  endtask

  initial begin
    logic [255:0] held;
    reset = 1'b1;
    din_a = 16'd0; din_b = 16'd0; din_c = 16'd0;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
`ifdef MAXPOOL_WINDOW_BACKPRESSURE_EN
    out_rdy_a = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;

    // Test 1: 4x4 continuous frame 0..15.
    for (int p = 0; p < 16; p++) begin
      beat(0, 16'(p));
      if (p == 5) chk("t1 first window", act_win(0), {192'd0, 64'h0005_0004_0001_0000});
    end
    chk("t1 window count", 256'(win_cnt[0]), 256'd4);
    idle(0, 2);

    // Test 2: same frame with random 1-3 cycle gaps.
    for (int p = 0; p < 16; p++) begin
      beat(0, 16'(p));
      idle(0, int'($urandom_range(1, 3)));
    end
    chk("t2 window count", 256'(win_cnt[0]), 256'd8);

    // Test 5: S=3 6x6 frame 0..35.
    for (int p = 0; p < 36; p++) begin
      beat(2, 16'(p));
      if (p == 14)
        chk("t5 first window", act_win(2),
            {112'd0, 144'h000E_000D_000C_0008_0007_0006_0002_0001_0000});
    end
    chk("t5 window count", 256'(win_cnt[2]), 256'd4);

    // Test 3: two back-to-back 28x28 frames, value row*28+col.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 784; p++) begin
        beat(1, 16'(p));
        if (f == 1 && p == 29)
          chk("t3 frame2 window0", act_win(1), {192'd0, 64'h001D_001C_0001_0000});
        if (p == 783) chk($sformatf("t3 count f%0d", f), 256'(win_cnt[1]), 256'(196 * (f + 1)));
      end
    end

    // Test 4: random frame, reset arrives together with pixel 41 (an emitting pixel).
    for (int p = 0; p < 41; p++) beat(1, 16'($urandom_range(1000, 60000)));
    reset = 1'b1;
    set_in(1, 1'b1, 16'hBEEF);
    @(posedge clk); #1;
    set_in(1, 1'b0, 16'd0);
    reset = 1'b0;
    check_reset_state();
    for (int d = 0; d < 3; d++) pos[d] = 0;
    win_cnt[1] = 0;
    for (int p = 0; p < 784; p++) begin
      beat(1, 16'(p));
      if (p == 29) chk("t4 fresh window0", act_win(1), {192'd0, 64'h001D_001C_0001_0000});
    end
    chk("t4 window count", 256'(win_cnt[1]), 256'd196);

`ifdef MAXPOOL_WINDOW_BACKPRESSURE_EN
    // Test 6: hold the first window for 5 cycles while pixel 6 waits.
    for (int p = 0; p < 5; p++) beat(0, 16'(p));
    out_rdy_a = 1'b0;
    beat(0, 16'd5);
    held = act_win(0);
    for (int k = 0; k < 5; k++) begin
      set_in(0, 1'b1, 16'd6);
      chk("t6 ready low", {255'd0, rdy_a}, 256'd0);
      @(posedge clk); #1;
      chk("t6 held valid", {255'd0, wv_a}, {255'd0, 1'b1});
      chk("t6 held window", act_win(0), {192'd0, 64'h0005_0004_0001_0000});
    end
    set_in(0, 1'b0, 16'd6);
    out_rdy_a = 1'b1;
    for (int p = 6; p < 16; p++) beat(0, 16'(p));
    chk("t6 held equals first", held, {192'd0, 64'h0005_0004_0001_0000});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
